// File: rtl/biu_pkg.sv
// rtl/biu_pkg.sv - shared widths and helpers for the bus interface unit
package biu_pkg;

    localparam int BIU_AW = 32;
    localparam int BIU_DW = 32;

    // Channel-id width; a single channel still needs one bit of storage.
    function automatic int chid_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/biu_arb_if.sv
// rtl/biu_arb_if.sv - requester channels plus split-transaction memory port
interface biu_arb_if
    import biu_pkg::*;
#(
    parameter int AW  = BIU_AW,
    parameter int DW  = BIU_DW,
    parameter int NCH = 2
);
    localparam int SW = strb_w(DW);

    logic [NCH-1:0]    req_vld;
    logic [NCH-1:0]    req_rdy;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    req_wen;
    logic [NCH*SW-1:0] req_wstrb;
    logic [NCH-1:0]    rsp_vld;
    logic [NCH-1:0]    rsp_rdy;
    logic [DW-1:0]     rsp_rdata;
    logic              mem_req_vld;
    logic              mem_req_rdy;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wen;
    logic [SW-1:0]     mem_wstrb;
    logic              mem_rsp_vld;
    logic              mem_rsp_rdy;
    logic [DW-1:0]     mem_rsp_rdata;
    logic              err_unexp_rsp;

    // The arbiter's view: serves the requesters, drives the memory port.
    modport slave (
        input  req_vld, req_addr, req_wdata, req_wen, req_wstrb, rsp_rdy,
        input  mem_req_rdy, mem_rsp_vld, mem_rsp_rdata,
        output req_rdy, rsp_vld, rsp_rdata,
        output mem_req_vld, mem_addr, mem_wdata, mem_wen, mem_wstrb, mem_rsp_rdy,
        output err_unexp_rsp
    );

    // The environment's view: requesters and memory model.
    modport master (
        output req_vld, req_addr, req_wdata, req_wen, req_wstrb, rsp_rdy,
        output mem_req_rdy, mem_rsp_vld, mem_rsp_rdata,
        input  req_rdy, rsp_vld, rsp_rdata,
        input  mem_req_vld, mem_addr, mem_wdata, mem_wen, mem_wstrb, mem_rsp_rdy,
        input  err_unexp_rsp
    );

endinterface

// File: rtl/biu_id_fifo.sv
// rtl/biu_id_fifo.sv - in-order FIFO of issuing channel ids
module biu_id_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[PW-1:0]];

    // Pointer advance; overflow and underflow are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Id storage, no reset needed: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/biu_arb.sv
// rtl/biu_arb.sv - round-robin multi-channel bus interface unit
module biu_arb
    import biu_pkg::*;
#(
    parameter int AW  = BIU_AW,
    parameter int DW  = BIU_DW,
    parameter int NCH = 2,
    parameter int OST = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    biu_arb_if.slave  bus
);
    localparam int CW = chid_w(NCH);
    localparam int SW = strb_w(DW);
    localparam int PW = $clog2(OST);

    logic          run;
    logic          lock;
    logic [CW-1:0] lock_idx;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] rr_idx;
    logic [CW-1:0] gnt_idx;
    logic [CW-1:0] head;
    logic          ost_full;
    logic          id_empty;
    logic          unused_full;
    logic [PW:0]   id_count;
    logic          push;
    logic          pop;
    logic          err_q;

    // First valid channel at or after the round-robin pointer.
    always_comb begin : rr_search
        int  c;
        logic found;
        c      = 0;
        found  = 1'b0;
        rr_idx = rr_ptr;
        for (int k = 0; k < NCH; k++) begin
            c = (int'(rr_ptr) + k) % NCH;
            if (!found && bus.req_vld[c]) begin
                found  = 1'b1;
                rr_idx = CW'(c);
            end
        end
    end

    // A stalled request keeps its grant so mem_* stays stable.
    assign gnt_idx  = lock ? lock_idx : rr_idx;
    assign ost_full = (id_count == (PW+1)'(OST));

    assign bus.mem_req_vld = run && (|bus.req_vld) && !ost_full;
    assign bus.mem_addr    = bus.req_addr[gnt_idx*AW +: AW];
    assign bus.mem_wdata   = bus.req_wdata[gnt_idx*DW +: DW];
    assign bus.mem_wen     = bus.req_wen[gnt_idx];
    assign bus.mem_wstrb   = bus.req_wstrb[gnt_idx*SW +: SW];
    assign push            = bus.mem_req_vld && bus.mem_req_rdy;

    // Requester ready mirrors the memory handshake for the granted channel.
    always_comb begin
        bus.req_rdy = '0;
        if (push)
            bus.req_rdy[gnt_idx] = 1'b1;
    end

    // Responses are routed to the oldest outstanding channel.
    always_comb begin
        bus.rsp_vld = '0;
        if (run && bus.mem_rsp_vld && !id_empty)
            bus.rsp_vld[head] = 1'b1;
    end

    assign bus.mem_rsp_rdy   = run && !id_empty && bus.rsp_rdy[head];
    assign bus.rsp_rdata     = bus.mem_rsp_rdata;
    assign pop               = bus.mem_rsp_vld && bus.mem_rsp_rdy;
    assign bus.err_unexp_rsp = err_q;

    biu_id_fifo #(
        .W     (CW),
        .DEPTH (OST)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (gnt_idx),
        .pop   (pop),
        .head  (head),
        .full  (unused_full),
        .empty (id_empty),
        .count (id_count)
    );

    // Output enable after reset, rr pointer, grant lock and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            lock     <= 1'b0;
            lock_idx <= '0;
            rr_ptr   <= '0;
            err_q    <= 1'b0;
        end else begin
            run <= 1'b1;
            if (push) begin
                lock   <= 1'b0;
                rr_ptr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (bus.mem_req_vld) begin
                lock     <= 1'b1;
                lock_idx <= gnt_idx;
            end
            if (run && bus.mem_rsp_vld && id_empty)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_biu_arb.sv
// tb/tb_biu_arb.sv - randomized and directed bench for biu_arb
module tb_biu_arb;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NCH = 2;
    localparam int OST = 4;
    localparam int SW  = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    biu_arb_if #(.AW(AW), .DW(DW), .NCH(NCH)) bus ();

    biu_arb #(.AW(AW), .DW(DW), .NCH(NCH), .OST(OST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int             ch;
        logic [DW-1:0]  data;
    } ost_t;

    ost_t           q[$];
    int             m_rr;
    int             m_lock_ch;
    bit             m_lock;
    bit             m_err;
    bit             m_run;
    bit             hold[NCH];
    logic [AW-1:0]  r_addr[NCH];
    logic [DW-1:0]  r_wdata[NCH];
    logic           r_wen[NCH];
    logic [SW-1:0]  r_wstrb[NCH];
    logic [NCH-1:0] last_req_rdy;
    logic [NCH-1:0] last_rsp_vld;
    logic           last_mrr;
    int             total = 0;
    int             bad   = 0;
    int             hs;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a, input logic [DW-1:0] w);
        return {a[15:0], w[15:0]} ^ 32'h5a5a_c3c3;
    endfunction

    task automatic new_req(input int ch);
        hold[ch]    = 1'b1;
        r_addr[ch]  = $urandom;
        r_wdata[ch] = $urandom;
        r_wen[ch]   = 1'($urandom_range(0, 1));
        r_wstrb[ch] = r_wen[ch] ? SW'($urandom) : '0;
    endtask

    task automatic drive_req();
        for (int i = 0; i < NCH; i++) begin
            bus.req_vld[i]              = hold[i];
            bus.req_addr[i*AW +: AW]    = r_addr[i];
            bus.req_wdata[i*DW +: DW]   = r_wdata[i];
            bus.req_wen[i]              = r_wen[i];
            bus.req_wstrb[i*SW +: SW]   = r_wstrb[i];
        end
    endtask

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic cycle(input logic [NCH-1:0] want, input bit mrdy, input bit rsp_en,
                         input bit force_rsp, input logic [NCH-1:0] rrdy);
        int gnt;
        int head;
        bit any, full, empty, e_mvld, e_mrr;
        logic [NCH-1:0] e_rrdy, e_rspv;
        ost_t e;
        for (int i = 0; i < NCH; i++)
            if (!hold[i] && want[i]) new_req(i);
        drive_req();
        bus.mem_req_rdy   = mrdy;
        bus.rsp_rdy       = rrdy;
        bus.mem_rsp_vld   = rsp_en && (q.size() != 0 || force_rsp);
        bus.mem_rsp_rdata = (q.size() != 0) ? q[0].data : DW'($urandom);
        #1;
        any   = 1'b0;
        gnt   = 0;
        for (int i = 0; i < NCH; i++) any |= hold[i];
        if (m_lock) gnt = m_lock_ch;
        else begin
            for (int k = NCH - 1; k >= 0; k--)
                if (hold[(m_rr + k) % NCH]) gnt = (m_rr + k) % NCH;
        end
        full   = (q.size() == OST);
        empty  = (q.size() == 0);
        head   = empty ? 0 : q[0].ch;
        e_mvld = m_run && any && !full;
        e_rrdy = (e_mvld && mrdy) ? NCH'(1 << gnt) : '0;
        e_rspv = (m_run && bus.mem_rsp_vld && !empty) ? NCH'(1 << head) : '0;
        e_mrr  = m_run && !empty && rrdy[head];
        check_val("mem_req_vld", bus.mem_req_vld, e_mvld);
        check_val("req_rdy", bus.req_rdy, e_rrdy);
        if (e_mvld) begin
            check_val("mem_addr", bus.mem_addr, r_addr[gnt]);
            check_val("mem_wdata", bus.mem_wdata, r_wdata[gnt]);
            check_val("mem_wen", bus.mem_wen, r_wen[gnt]);
            check_val("mem_wstrb", bus.mem_wstrb, r_wstrb[gnt]);
        end
        check_val("rsp_vld", bus.rsp_vld, e_rspv);
        check_val("mem_rsp_rdy", bus.mem_rsp_rdy, e_mrr);
        if (e_rspv != 0) check_val("rsp_rdata", bus.rsp_rdata, q[0].data);
        check_val("err_unexp_rsp", bus.err_unexp_rsp, m_err);
        last_req_rdy = bus.req_rdy;
        last_rsp_vld = bus.rsp_vld;
        last_mrr     = bus.mem_rsp_rdy;
        @(posedge clk);
        if (m_run) begin
            if (bus.mem_rsp_vld && empty) m_err = 1'b1;
            if (bus.mem_rsp_vld && e_mrr) void'(q.pop_front());
            if (e_mvld && mrdy) begin
                e.ch   = gnt;
                e.data = mem_data(r_addr[gnt], r_wdata[gnt]);
                q.push_back(e);
                hold[gnt] = 1'b0;
                m_rr      = (gnt + 1) % NCH;
                m_lock    = 1'b0;
            end else if (e_mvld) begin
                m_lock    = 1'b1;
                m_lock_ch = gnt;
            end
        end
        m_run = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q.size() != 0 || hold[0] || hold[1]) && guard < 64) begin
            cycle('0, 1'b1, 1'b1, 1'b0, '1);
            guard++;
        end
        check_val("drain_timeout", guard >= 64, 1'b0);
    endtask

    initial begin
        m_rr = 0; m_lock = 0; m_lock_ch = 0; m_err = 0; m_run = 0;
        for (int i = 0; i < NCH; i++) hold[i] = 1'b0;
        new_req(0);
        new_req(1);
        drive_req();
        bus.mem_req_rdy   = 1'b1;
        bus.rsp_rdy       = '1;
        bus.mem_rsp_vld   = 1'b1;
        bus.mem_rsp_rdata = '0;

        // reset with requests and a response pending
        repeat (3) begin
            @(negedge clk);
            #1;
            check_val("rst_mem_req_vld", bus.mem_req_vld, 1'b0);
            check_val("rst_req_rdy", bus.req_rdy, 2'b00);
            check_val("rst_rsp_vld", bus.rsp_vld, 2'b00);
            check_val("rst_mem_rsp_rdy", bus.mem_rsp_rdy, 1'b0);
            check_val("rst_err", bus.err_unexp_rsp, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(2'b11, 1'b1, 1'b0, 1'b0, 2'b11);

        // round robin with both channels always valid
        for (int i = 0; i < 8; i++) begin
            cycle(2'b11, 1'b1, 1'b1, 1'b0, 2'b11);
            check_val("rr_gnt", last_req_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        drain();

        // lock: ch1 at 0x100 stalls while ch0 arrives
        new_req(1);
        cycle('0, 1'b1, 1'b0, 1'b0, 2'b11);
        drain();
        hold[1] = 1'b1; r_addr[1] = 32'h100; r_wdata[1] = 32'h1234_5678;
        r_wen[1] = 1'b0; r_wstrb[1] = '0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) new_req(0);
            cycle('0, 1'b0, 1'b0, 1'b0, 2'b11);
            check_val("lock_addr", bus.mem_addr, 32'h100);
        end
        cycle('0, 1'b1, 1'b0, 1'b0, 2'b11);
        check_val("lock_hs", last_req_rdy, 2'b10);
        check_val("lock_next_addr", bus.mem_addr, r_addr[0]);
        drain();

        // outstanding limit and no pop-to-push bypass
        hs = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(2'b01, 1'b1, 1'b0, 1'b0, 2'b11);
            hs += int'(last_req_rdy[0]);
        end
        check_val("ost_hs", hs, 4);
        check_val("ost_mem_req_vld", bus.mem_req_vld, 1'b0);
        check_val("ost_req_rdy", bus.req_rdy, 2'b00);
        cycle(2'b01, 1'b1, 1'b1, 1'b0, 2'b11);
        check_val("ost_no_bypass", last_req_rdy, 2'b00);
        cycle(2'b01, 1'b1, 1'b0, 1'b0, 2'b11);
        check_val("ost_issue_after_pop", last_req_rdy, 2'b01);
        drain();

        // response backpressure on ch1
        new_req(1);
        cycle('0, 1'b1, 1'b0, 1'b0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            cycle('0, 1'b1, 1'b1, 1'b0, 2'b01);
            check_val("bp_rsp_vld", last_rsp_vld, 2'b10);
            check_val("bp_mem_rsp_rdy", last_mrr, 1'b0);
        end
        cycle('0, 1'b1, 1'b1, 1'b0, 2'b11);
        check_val("bp_pop", last_mrr, 1'b1);
        check_val("bp_empty", q.size(), 0);

        // random traffic
        for (int i = 0; i < 600; i++)
            cycle(NCH'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 1'b0, NCH'($urandom_range(0, 3)));
        drain();

        // unexpected response with nothing outstanding
        cycle('0, 1'b1, 1'b1, 1'b1, 2'b11);
        check_val("unexp_rsp_vld", last_rsp_vld, 2'b00);
        check_val("unexp_mem_rsp_rdy", last_mrr, 1'b0);
        check_val("unexp_err", bus.err_unexp_rsp, 1'b1);
        repeat (3) cycle('0, 1'b1, 1'b0, 1'b0, 2'b11);
        check_val("unexp_err_sticky", bus.err_unexp_rsp, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/biu_arb.md
Name: biu_arb

Overview:
- Parametrised multi-channel bus interface unit.
- Arbitrates NCH requester channels (e.g. ifu fetch, lsu load/store, debug) onto one split-transaction memory port using round-robin.
- Tracks up to OST outstanding transactions and routes in-order memory responses back to the issuing channel.
- Replaces the single-requester biu at the core top; every channel and the memory port use valid/ready handshakes.

Parameters:
- AW, 32, address width
- DW, 32, data width; must be a multiple of 8
- NCH, 2, number of requester channels, 2..8
- OST, 4, maximum outstanding transactions; power of 2, at least 2

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_vld  input  NCH  per-channel request valid
- req_rdy  output  NCH  per-channel request ready
- req_addr  input  NCH*AW  channel i occupies bits [i*AW +: AW]
- req_wdata  input  NCH*DW  per-channel write data
- req_wen  input  NCH  1=write, 0=read
- req_wstrb  input  NCH*DW/8  byte strobes, write only
- rsp_vld  output  NCH  per-channel response valid
- rsp_rdy  input  NCH  per-channel response ready
- rsp_rdata  output  DW  response data, shared by all channels; meaningful only for the channel whose rsp_vld is high
- mem_req_vld  output  1  memory request valid
- mem_req_rdy  input  1  memory request ready
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_wen  output  1  memory write enable
- mem_wstrb  output  DW/8  memory byte strobes
- mem_rsp_vld  input  1  memory response valid; one response per request, in order, writes included
- mem_rsp_rdy  output  1  memory response ready
- mem_rsp_rdata  input  DW  memory read data
- err_unexp_rsp  output  1  sticky: response arrived with nothing outstanding

Behaviour:
- **Reset** (async, rst_n=0):
  - rr pointer = 0, lock = 0, ID FIFO empty, err_unexp_rsp = 0.
  - All vld/rdy outputs are 0 during and immediately after reset.
  - Reset mid-transaction discards outstanding IDs; the memory side must be reset together with this block.
- **Arbitration:**
  - Round-robin over req_vld, starting the search at rr pointer.
  - grant is one-hot, computed combinationally when lock=0.
  - mem_req_vld = |req_vld && !ost_full.
  - mem_* fields are muxed from the granted channel.
- **Grant lock:**
  - If mem_req_vld=1 and mem_req_rdy=0, set lock and hold the grant register.
  - mem_* must stay stable until the handshake; a higher-priority arrival must not change the grant.
  - Lock clears on handshake.
- **Request handshake:**
  - req_rdy[i] = grant[i] && mem_req_rdy && !ost_full.
  - On handshake, push channel index (clog2(NCH) bits) into the ID FIFO.
  - rr pointer becomes (granted index + 1) mod NCH.
  - Zero added latency: request and memory handshakes occur in the same cycle.
- **Outstanding limit:**
  - ost_full means the FIFO count equals OST.
  - When full, no request is issued, even if a response pops in the same cycle; there is no pop-to-push bypass.
- **Response routing:**
  - head = ID FIFO head.
  - rsp_vld[head] = mem_rsp_vld && !empty; all other rsp_vld bits are 0.
  - rsp_rdata = mem_rsp_rdata, passed combinationally.
  - mem_rsp_rdy = !empty && rsp_rdy[head].
  - Pop on mem_rsp_vld && mem_rsp_rdy.
- **Unexpected response:**
  - mem_rsp_vld with the FIFO empty (count sampled before any same-cycle push): mem_rsp_rdy=0 and err_unexp_rsp is set.
  - err_unexp_rsp stays set until reset.
  - A response in the same cycle as its own issue is therefore illegal (minimum memory latency 1).
- **Simultaneous push and pop** with count < OST: count unchanged, head advances.
- **Pointers:** FIFO read/write pointers are clog2(OST)+1 bits with natural wrap; full/empty are decided by the MSB compare.
- **Single requester:** a channel requesting alone is granted every cycle (back-to-back issue) until ost_full.

Decomposition:
- Package biu_pkg:
  - chid width function clog2(NCH)
  - default AW/DW localparams
  - strobe width DW/8
- Sub-module biu_id_fifo:
  - Synchronous FIFO with async reset, width clog2(NCH), depth OST.
  - Outputs head, full, empty, count.
- Round-robin grant logic stays inline in biu_arb.

Test Plan:
1. Reset:
   - Stimulus: rst_n low with req_vld=2'b11 and mem_rsp_vld=1.
   - Required: all vld/rdy outputs 0, err_unexp_rsp=0; first grant after release goes to ch0.
2. Round-robin:
   - Stimulus: NCH=2, both channels continuously valid, mem_req_rdy=1, memory latency 2.
   - Required: grants alternate ch0, ch1, ch0, ch1; responses go to rsp_vld 01, 10, 01, 10 carrying matching rdata.
3. Lock:
   - Stimulus: ch1 requests addr 0x100 with mem_req_rdy=0 for 3 cycles; ch0 asserts in cycle 2.
   - Required: mem_addr holds 0x100 until handshake; ch0 is granted next.
4. Outstanding limit:
   - Stimulus: OST=4, no memory responses, ch0 issues.
   - Required: exactly 4 handshakes, then req_rdy=0 and mem_req_vld=0.
   - Then one response: the next request is accepted one cycle after the pop, not in the same cycle.
5. Response backpressure:
   - Stimulus: rsp_rdy[1]=0 while the head ID is 1.
   - Required: mem_rsp_rdy=0 and the response is held; rsp_rdy[1] rising completes the pop.
6. Unexpected response:
   - Stimulus: mem_rsp_vld=1 with the FIFO empty.
   - Required: err_unexp_rsp=1 next cycle and stays 1; no rsp_vld asserted.
